// File: rtl/dll_multi_cntrl_if.sv
// Command/response channel of the multi-queue linked-list controller.
// The master is the arbiter; the slave is the list controller.
interface dll_multi_cntrl_if #(
  parameter int ID_W  = 2,
  parameter int PTR_W = 4
);
  logic             cmd_vld;
  logic             cmd_rdy;
  logic [2:0]       cmd_op;
  logic [ID_W-1:0]  cmd_id;
  logic [PTR_W-1:0] cmd_ptr;
  logic             rsp_vld;
  logic             rsp_err;
  logic [PTR_W-1:0] rsp_ptr;

  modport master (
    output cmd_vld, cmd_op, cmd_id, cmd_ptr,
    input  cmd_rdy, rsp_vld, rsp_err, rsp_ptr
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_id, cmd_ptr,
    output cmd_rdy, rsp_vld, rsp_err, rsp_ptr
  );
endinterface

// File: rtl/dll_multi_cntrl.sv
// Multi-queue doubly-linked-list controller over a shared node pool.
// One command per two cycles; response registered after EXEC.
module dll_multi_cntrl #(
  parameter int ID_N  = 4,
  parameter int PTR_N = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  dll_multi_cntrl_if.slave         bus,
  output logic                     full_r,
  output logic                     empty_r,
  output logic [ID_N-1:0]          nempty_r,
  output logic [$clog2(PTR_N):0]   free_cnt_r
);
  localparam int ID_W  = $clog2(ID_N);
  localparam int PTR_W = $clog2(PTR_N);

  typedef enum logic {IDLE, EXEC} st_t;

  st_t              st, st_nx;
  logic [2:0]       op_q;
  logic [ID_W-1:0]  id_q;
  logic [PTR_W-1:0] ptr_q;

  logic [PTR_W-1:0] nxt  [PTR_N];
  logic [PTR_W-1:0] prv  [PTR_N];
  logic [ID_W-1:0]  own  [PTR_N];
  logic [PTR_W-1:0] head [ID_N];
  logic [PTR_W-1:0] tail [ID_N];
  logic [PTR_N-1:0] vld;
  logic [ID_N-1:0]  ne;
  logic [PTR_W:0]   fcnt;

  logic             is_push, is_pop, is_del;
  logic             front, err, is_h, is_t;
  logic [PTR_W-1:0] alloc, rem, rsp_p;
  logic             upd;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) st <= IDLE;
    else                 st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (bus.cmd_vld && bus.cmd_rdy)
              st_nx = EXEC;
      EXEC: st_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_rdy = rst_n && !clear && (st == IDLE);
  end

  always_comb begin
    alloc = '0;
    for (int i = PTR_N - 1; i >= 0; i--)
      if (!vld[i]) alloc = PTR_W'(i);
    is_push = 1'b0;
    is_pop  = 1'b0;
    is_del  = 1'b0;
    front   = 1'b0;
    unique case (1'b1)
      (op_q == 3'b000): begin
        is_pop = 1'b1;
        front  = 1'b1;
      end
      (op_q == 3'b001): is_pop = 1'b1;
      (op_q == 3'b010): begin
        is_push = 1'b1;
        front   = 1'b1;
      end
      (op_q == 3'b011): is_push = 1'b1;
      (op_q == 3'b100): is_del = 1'b1;
      default: ;
    endcase
    // pops are just unlinks of an endpoint
    rem = is_del ? ptr_q
        : (front ? head[id_q] : tail[id_q]);
    is_h = (head[id_q] == rem);
    is_t = (tail[id_q] == rem);
    err = (is_push && fcnt == '0)
       || (is_pop && !ne[id_q])
       || (is_del && (!vld[ptr_q]
                      || own[ptr_q] != id_q))
       || !(is_push || is_pop || is_del);
    rsp_p = err ? '0 : (is_push ? alloc : rem);
    upd = rst_n && !clear && (st == EXEC) && !err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      op_q        <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      vld         <= '0;
      ne          <= '0;
      fcnt        <= (PTR_W+1)'(PTR_N);
      bus.rsp_vld <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_ptr <= '0;
    end else begin
      bus.rsp_vld <= 1'b0;
      if (bus.cmd_vld && bus.cmd_rdy) begin
        op_q  <= bus.cmd_op;
        id_q  <= bus.cmd_id;
        ptr_q <= bus.cmd_ptr;
      end
      if (st == EXEC) begin
        bus.rsp_vld <= 1'b1;
        bus.rsp_err <= err;
        bus.rsp_ptr <= rsp_p;
        if (!err && is_push) begin
          vld[alloc] <= 1'b1;
          ne[id_q]   <= 1'b1;
          fcnt       <= fcnt - 1'b1;
        end else if (!err) begin
          vld[rem] <= 1'b0;
          if (is_h && is_t) ne[id_q] <= 1'b0;
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // link fields are don't-care while a node or list is unused
  always_ff @(posedge clk) begin
    if (upd && is_push) begin
      own[alloc] <= id_q;
      if (!ne[id_q]) begin
        head[id_q] <= alloc;
        tail[id_q] <= alloc;
      end else if (front) begin
        prv[head[id_q]] <= alloc;
        nxt[alloc]      <= head[id_q];
        head[id_q]      <= alloc;
      end else begin
        nxt[tail[id_q]] <= alloc;
        prv[alloc]      <= tail[id_q];
        tail[id_q]      <= alloc;
      end
    end else if (upd && !(is_h && is_t)) begin
      if (is_h)
        head[id_q] <= nxt[rem];
      else if (is_t)
        tail[id_q] <= prv[rem];
      else begin
        nxt[prv[rem]] <= nxt[rem];
        prv[nxt[rem]] <= prv[rem];
      end
    end
  end

  assign full_r     = (fcnt == '0);
  assign empty_r    = (fcnt == (PTR_W+1)'(PTR_N));
  assign nempty_r   = ne;
  assign free_cnt_r = fcnt;
endmodule

// File: tb/tb_dll_multi_cntrl.sv
// Scoreboard bench for dll_multi_cntrl against a queue-based list model.
// Directed scenarios followed by randomized mixed traffic.
module tb_dll_multi_cntrl;
  localparam int ID_N  = 4;
  localparam int PTR_N = 16;
  localparam int ID_W  = 2;
  localparam int PTR_W = 4;

  typedef struct {
    bit err;
    int ptr;
    int ne;
    int fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic full_r, empty_r;
  logic [ID_N-1:0] nempty_r;
  logic [PTR_W:0]  free_cnt_r;

  dll_multi_cntrl_if #(.ID_W(ID_W), .PTR_W(PTR_W)) bus();

  dll_multi_cntrl #(.ID_N(ID_N), .PTR_N(PTR_N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus),
    .full_r     (full_r),
    .empty_r    (empty_r),
    .nempty_r   (nempty_r),
    .free_cnt_r (free_cnt_r)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   mq[ID_N][$];
  bit   used[PTR_N];
  int   checks = 0;
  int   passes = 0;
  int   rsp_seen = 0;

  task automatic chk(input string nm,
                     input int act, input int ex);
    checks++;
    if (act == ex) passes++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, ex);
  endtask

  task automatic model_status(inout exp_t e);
    int tot = 0;
    e.ne = 0;
    for (int i = 0; i < ID_N; i++) begin
      if (mq[i].size() != 0) e.ne |= (1 << i);
      tot += mq[i].size();
    end
    e.fc = PTR_N - tot;
  endtask

  task automatic model_clear();
    for (int i = 0; i < ID_N; i++) mq[i].delete();
    for (int i = 0; i < PTR_N; i++) used[i] = 0;
  endtask

  task automatic model(input int op, input int id,
                       input int ptr, output exp_t e);
    int n, idx;
    e.err = 0;
    e.ptr = 0;
    case (op)
      0, 1: begin
        if (mq[id].size() == 0) e.err = 1;
        else begin
          n = (op == 0) ? mq[id].pop_front()
                        : mq[id].pop_back();
          used[n] = 0;
          e.ptr = n;
        end
      end
      2, 3: begin
        n = -1;
        for (int i = PTR_N - 1; i >= 0; i--)
          if (!used[i]) n = i;
        if (n < 0) e.err = 1;
        else begin
          used[n] = 1;
          if (op == 2) mq[id].push_front(n);
          else         mq[id].push_back(n);
          e.ptr = n;
        end
      end
      4: begin
        idx = -1;
        for (int k = 0; k < mq[id].size(); k++)
          if (mq[id][k] == ptr) idx = k;
        if (idx < 0) e.err = 1;
        else begin
          mq[id].delete(idx);
          used[ptr] = 0;
          e.ptr = ptr;
        end
      end
      default: e.err = 1;
    endcase
    model_status(e);
  endtask

  task automatic issue(input int op, input int id,
                       input int ptr);
    int n = 0;
    @(negedge clk);
    bus.cmd_op  = 3'(op);
    bus.cmd_id  = ID_W'(id);
    bus.cmd_ptr = PTR_W'(ptr);
    bus.cmd_vld = 1'b1;
    while (!bus.cmd_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("cmd_rdy_timeout", 0, 1);
    @(posedge clk);
    #1 bus.cmd_vld = 1'b0;
  endtask

  task automatic cmd(input int op, input int id,
                     input int ptr);
    exp_t e;
    model(op, id, ptr, e);
    exp_q.push_back(e);
    issue(op, id, ptr);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_clear();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_vld) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rsp: got ptr %0d err %0d expected none",
                 bus.rsp_ptr, bus.rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_err", int'(bus.rsp_err), int'(e.err));
        chk("rsp_ptr", int'(bus.rsp_ptr), e.ptr);
        chk("nempty_r", int'(nempty_r), e.ne);
        chk("free_cnt_r", int'(free_cnt_r), e.fc);
        chk("full_r", int'(full_r), int'(e.fc == 0));
        chk("empty_r", int'(empty_r),
            int'(e.fc == PTR_N));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, id, ptr, r, seen;
    bus.cmd_vld = 1'b0;
    bus.cmd_op  = '0;
    bus.cmd_id  = '0;
    bus.cmd_ptr = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_rdy", int'(bus.cmd_rdy), 0);
    chk("rst_rsp_vld", int'(bus.rsp_vld), 0);
    chk("rst_rsp_err", int'(bus.rsp_err), 0);
    chk("rst_rsp_ptr", int'(bus.rsp_ptr), 0);
    chk("rst_full", int'(full_r), 0);
    chk("rst_empty", int'(empty_r), 1);
    chk("rst_nempty", int'(nempty_r), 0);
    chk("rst_free", int'(free_cnt_r), PTR_N);
    rst_n = 1'b1;

    repeat (3) cmd(3, 0, 0);
    cmd(0, 0, 0);
    cmd(1, 0, 0);
    cmd(0, 0, 0);
    drain();

    repeat (PTR_N) cmd(2, 1, 0);
    cmd(2, 1, 0);
    cmd(3, 2, 0);
    repeat (PTR_N) cmd(1, 1, 0);
    drain();

    repeat (3) cmd(3, 0, 0);
    cmd(4, 0, 1);
    cmd(0, 0, 0);
    cmd(0, 0, 0);
    cmd(3, 0, 0);
    cmd(4, 1, 0);
    cmd(4, 0, 5);
    cmd(0, 0, 0);
    cmd(0, 3, 0);
    cmd(6, 2, 0);
    drain();

    cmd(3, 2, 0);
    cmd(2, 3, 0);
    drain();
    seen = rsp_seen;
    issue(3, 2, 0);
    clear = 1'b1;
    @(negedge clk);
    chk("clear_cmd_rdy", int'(bus.cmd_rdy), 0);
    @(posedge clk);
    #1 clear = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
    chk("clear_no_rsp", rsp_seen, seen);
    chk("clear_empty", int'(empty_r), 1);
    chk("clear_free", int'(free_cnt_r), PTR_N);
    chk("clear_nempty", int'(nempty_r), 0);
    chk("clear_full", int'(full_r), 0);

    for (int t = 0; t < 400; t++) begin
      r  = $urandom_range(0, 11);
      id = $urandom_range(0, ID_N - 1);
      ptr = $urandom_range(0, PTR_N - 1);
      case (r)
        0, 1:    op = 0;
        2, 3:    op = 1;
        4, 5:    op = 2;
        6, 7:    op = 3;
        8, 9:    op = 4;
        10:      op = 3;
        default: op = $urandom_range(5, 7);
      endcase
      if (op == 4 && mq[id].size() != 0
          && $urandom_range(0, 3) != 0)
        ptr = mq[id][$urandom_range(0,
                mq[id].size() - 1)];
      cmd(op, id, ptr);
      if (t % 100 == 99) begin
        drain();
        pulse_clear();
        @(negedge clk);
        chk("rnd_clear_free", int'(free_cnt_r),
            PTR_N);
      end
    end
    drain();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
